// File: rtl/miner_pkg.sv
// Shared definitions for the miner host-link blocks: UART transmit states and framing constants.
package miner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int NONCE_BYTES    = 4;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous nonce queue; a push into a full queue is legal when a pop happens in the same cycle.
module nonce_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // When full, wptr == rptr: the head is read out before the edge overwrites its slot.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_tx.sv
// Queues golden nonces and sends each as four 8N1 bytes, LSB byte first, on the host UART TX line.
module golden_nonce_tx
  import miner_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          is_golden_ticket,
  input  logic [31:0]                   golden_nonce,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic [1:0]    byte_inc;
  logic [31:0]   shreg, shreg_n;
  logic [7:0]    cur_byte, cur_n;
  logic          tx_n;
  logic          baud_tc;
  logic          push, pop, full, empty;
  logic [31:0]   head;

  assign push     = is_golden_ticket && (!full || pop);
  assign baud_tc  = (baud_cnt == BAUD_LAST);
  assign byte_inc = byte_idx + 2'd1;
  assign tx_busy  = (state != ST_IDLE);

  nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (sys_clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (golden_nonce),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_idx;
    shreg_n = shreg;
    cur_n   = cur_byte;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          byte_n  = 2'd0;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cur_n   = shreg[{byte_idx, 3'b000} +: 8];
        baud_n  = '0;
        bit_n   = 3'd0;
        state_n = ST_START;
      end
      ST_START: begin
        if (baud_tc) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = ST_DATA;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_tc) begin
          baud_n = '0;
          if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
            bit_n   = 3'd0;
            state_n = ST_STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_tc) begin
          baud_n = '0;
          if (byte_idx != 2'(NONCE_BYTES - 1)) begin
            // Next byte is selected here so bytes of one nonce run with no gap.
            byte_n  = byte_inc;
            cur_n   = shreg[{byte_inc, 3'b000} +: 8];
            state_n = ST_START;
          end else if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            byte_n  = 2'd0;
            state_n = ST_LOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Line level follows the state being entered so tx_serial comes straight from a flop.
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = cur_n[bit_n];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      byte_idx  <= 2'd0;
      shreg     <= '0;
      cur_byte  <= '0;
      tx_serial <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      byte_idx  <= byte_n;
      shreg     <= shreg_n;
      cur_byte  <= cur_n;
      tx_serial <= tx_n;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (is_golden_ticket && !push && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Randomized bench for golden_nonce_tx against a queue-and-timeline reference model of the UART link.
module tb_golden_nonce_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 40 * CPB;

  logic        sys_clk;
  logic        reset;
  logic        is_golden_ticket;
  logic [31:0] golden_nonce;
  logic        tx_serial;
  logic        tx_busy;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;

  golden_nonce_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .sys_clk          (sys_clk),
    .reset            (reset),
    .is_golden_ticket (is_golden_ticket),
    .golden_nonce     (golden_nonce),
    .tx_serial        (tx_serial),
    .tx_busy          (tx_busy),
    .fifo_count       (fifo_count),
    .drop_count       (drop_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a nonce popped at edge P owns the line for edges P+1 .. P+40*CPB,
  // after which the next queued nonce may be popped.
  logic [31:0] q[$];
  logic [31:0] cur_nonce;
  int          cyc = 0;
  int          free_at = 0;
  int          pop_at = -100;
  logic        exp_tx = 1'b1;
  logic        exp_busy = 1'b0;
  int          exp_cnt = 0;
  int          exp_drop = 0;
  logic        chk_en = 1'b0;
  int          max_cnt = 0;

  always @(posedge sys_clk or posedge reset) begin
    int k, b, pos;
    if (reset) begin
      q.delete();
      free_at  = 0;
      pop_at   = -100;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_cnt  = 0;
      exp_drop = 0;
    end else begin
      cyc++;
      if (q.size() > 0 && cyc >= free_at) begin
        cur_nonce = q.pop_front();
        pop_at    = cyc;
        free_at   = cyc + 1 + FRAME;
      end
      if (is_golden_ticket) begin
        if (q.size() < DEPTH) q.push_back(golden_nonce);
        else if (exp_drop < 255) exp_drop++;
      end
      exp_busy = (cyc < free_at);
      exp_cnt  = q.size();
      exp_tx   = 1'b1;
      k = cyc - pop_at - 1;
      if (cyc < free_at && k >= 0) begin
        b   = k / CPB;
        pos = b % 10;
        if (pos == 0) exp_tx = 1'b0;
        else if (pos < 9) exp_tx = cur_nonce[(b / 10) * 8 + pos - 1];
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check_eq("tx_serial", tx_serial, exp_tx);
      check_eq("tx_busy", tx_busy, exp_busy);
      check_eq("fifo_count", fifo_count, exp_cnt);
      check_eq("drop_count", drop_count, exp_drop);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
  end

  // All tasks below start and end at a negedge.
  task automatic pulse(input logic [31:0] n);
    is_golden_ticket = 1'b1;
    golden_nonce     = n;
    @(negedge sys_clk);
    is_golden_ticket = 1'b0;
    golden_nonce     = $urandom;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge sys_clk);
    #2 reset = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 6000; i++) begin
      if (!tx_busy && fifo_count == 0) break;
      @(negedge sys_clk);
    end
    check_eq(tag, {tx_busy, fifo_count != 3'd0}, 2'b00);
  endtask

  initial begin
    is_golden_ticket = 1'b0;
    golden_nonce     = '0;
    reset            = 1'b0;
    #1 reset = 1'b1;
    @(negedge sys_clk);
    #2 reset = 1'b0;
    @(negedge sys_clk);
    chk_en = 1'b1;

    // Reset state
    check_eq("rst_tx", tx_serial, 1'b1);
    check_eq("rst_busy", tx_busy, 1'b0);
    check_eq("rst_cnt", fifo_count, 3'd0);
    check_eq("rst_drop", drop_count, 8'd0);

    // Single nonce: busy after 2 edges, line falls after 3
    pulse(32'h1234_5678);
    check_eq("t1_cnt_after_push", fifo_count, 3'd1);
    check_eq("t1_busy_before_load", tx_busy, 1'b0);
    @(negedge sys_clk);
    check_eq("t1_busy_load", tx_busy, 1'b1);
    check_eq("t1_tx_load", tx_serial, 1'b1);
    @(negedge sys_clk);
    check_eq("t1_tx_start", tx_serial, 1'b0);
    wait_cycles(FRAME);
    check_eq("t1_busy_done", tx_busy, 1'b0);
    wait_idle("t1_idle");

    // Back-to-back nonces
    do_reset();
    max_cnt = 0;
    pulse(32'hDEAD_BEEF);
    pulse(32'h0000_0001);
    wait_idle("t2_idle");
    check_eq("t2_peak_cnt", max_cnt, 1);

    // Overflow from idle
    do_reset();
    for (int i = 0; i < 6; i++) pulse($urandom);
    check_eq("t3_cnt", fifo_count, 3'd4);
    check_eq("t3_drop", drop_count, 8'd1);
    wait_idle("t3_idle");
    check_eq("t3_drop_final", drop_count, 8'd1);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 305; i++) pulse($urandom);
    check_eq("t4_drop_sat", drop_count, 8'd255);
    pulse($urandom);
    check_eq("t4_drop_hold", drop_count, 8'd255);
    wait_idle("t4_idle");

    // Reset in DATA bit 3 of byte 1 with a queued backlog and one drop
    do_reset();
    for (int i = 0; i < 6; i++) pulse($urandom);
    wait_cycles(53);
    check_eq("t5_busy_pre", tx_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_tx_rst", tx_serial, 1'b1);
    check_eq("t5_busy_rst", tx_busy, 1'b0);
    check_eq("t5_cnt_rst", fifo_count, 3'd0);
    check_eq("t5_drop_rst", drop_count, 8'd0);
    @(negedge sys_clk);
    #2 reset = 1'b0;
    @(negedge sys_clk);
    pulse($urandom);
    wait_idle("t5_idle");

    // Push coinciding with the STOP->LOAD pop while full
    do_reset();
    for (int i = 0; i < 5; i++) pulse($urandom);
    wait_cycles(FRAME - 3);
    check_eq("t6_cnt_full", fifo_count, 3'd4);
    pulse($urandom);
    check_eq("t6_cnt_kept", fifo_count, 3'd4);
    check_eq("t6_drop_kept", drop_count, 8'd0);
    wait_idle("t6_idle");

    // Random sparse traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) pulse($urandom);
      else @(negedge sys_clk);
    end
    wait_idle("t7_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
